llsc_ctrl: RTL and testbench
============================

LLSC_CTRL -- requirements
Module: llsc_ctrl

Interface
REQ-001 Parameters, one per line: ADDR_W, 32, memory address width; DATA_W, 32, register data width.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
REQ-003 clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high (`ResetEnable = 1'b1`); sampled only on the rising edge of clock.
REQ-005 stall  in  1  MEM stage held this cycle.
REQ-006 flush  in  1  pipeline flush (exception/eret).
REQ-007 mem_op  in  3  MEM-stage operation class: NOP, LOAD, STORE, LL, SC (codes from shared defines).
REQ-008 mem_addr  in  ADDR_W  effective byte address of the MEM-stage access.
REQ-009 LLbit_current  in  1  present LLbit register value.
REQ-010 sc_result  out  DATA_W  value SC writes to rt: 1 on success, 0 on failure.
REQ-011 sc_mem_we  out  1  SC store permitted to memory this cycle.
REQ-012 LLbit_we_wb  out  1  registered LLbit write enable, presented to the LLbit register in WB.
REQ-013 LLbit_value_wb  out  1  registered LLbit write value.
REQ-014 link_valid  out  1  a reservation is held.
REQ-015 link_addr  out  ADDR_W-2  reserved word address, mem_addr[ADDR_W-1:2].

Function
REQ-016 Effective LLbit SHALL be LLbit_value_wb when LLbit_we_wb=1, else LLbit_current; this is a combinational forward.
REQ-017 LL, not stalled: link_addr<=mem_addr[ADDR_W-1:2]; link_valid<=1; next cycle LLbit_we_wb=1 and LLbit_value_wb=1.
REQ-018 LL while link_valid=1: the reservation is overwritten with the new address.
REQ-019 SC success condition: effective LLbit=1, link_valid=1, and mem_addr[ADDR_W-1:2]==link_addr.
REQ-020 SC success drives sc_result=1 and sc_mem_we=1; failure drives sc_result=0 and sc_mem_we=0. Both are combinational in the same cycle.
REQ-021 Any non-stalled SC: link_valid<=0; next cycle LLbit_we_wb=1 and LLbit_value_wb=0.
REQ-022 STORE to the word equal to link_addr while link_valid=1: link_valid<=0; next cycle LLbit_we_wb=1 and LLbit_value_wb=0.
REQ-023 STORE to any other word, LOAD, or NOP: reservation unchanged; next cycle LLbit_we_wb=0.
REQ-024 Address compare is word-granular; mem_addr[1:0] is ignored.
REQ-025 stall=1: no reservation update; sc_mem_we=0; the WB registers load a bubble (LLbit_we_wb=0).
REQ-026 flush=1: link_valid<=0; WB registers clear to 0.
REQ-027 flush takes priority over stall and over every mem_op in the same cycle.
REQ-028 sc_result SHALL be 0 whenever mem_op is not SC.
REQ-029 Latency: the LLbit update reaches the WB outputs exactly 1 cycle after the MEM-stage op.

Reset
REQ-030 reset=1 at a clock edge: link_valid=0, link_addr=0, LLbit_we_wb=0, LLbit_value_wb=0.
REQ-031 reset SHALL take priority over flush, stall, and mem_op.
REQ-032 Mid-sequence reset (between LL and SC) SHALL cause the later SC to fail.

Structure
REQ-033 The mem_op codes, `ResetEnable`, and `WriteEnable` SHALL live in the shared defines file.
REQ-034 One sub-module is natural: llsc_link_reg, holding link_valid and link_addr with set/clear/hold controls. The compare logic and WB registers stay in llsc_ctrl.

Verification
REQ-035 LL at 0x100, then SC at 0x100 on the next cycle: sc_result=1 and sc_mem_we=1 via the forwarded LLbit, with LLbit_current still 0.
REQ-036 LL at 0x100, STORE at 0x102, then SC at 0x100: the store clears the reservation and the SC returns sc_result=0, sc_mem_we=0.
REQ-037 LL at 0x100, STORE at 0x104, then SC at 0x100: the reservation is kept and sc_result=1.
REQ-038 LL, then flush=1, then SC: sc_result=0. The flush cycle and the following cycle both show LLbit_we_wb=0; the SC itself then writes LLbit_value_wb=0.
REQ-039 SC held with stall=1 for 2 cycles, then released: sc_mem_we=0 while stalled; exactly one LLbit clear is issued, after release.
REQ-040 LL, then reset pulse, then SC: sc_result=0 and link_valid=0.

Source files
------------

// File: rtl/llsc_ctrl_pkg.sv
// Shared definitions for the LL/SC reservation controller.
// Holds the MEM-stage operation codes, reset/write-enable levels and the
// WB-stage LLbit record.  Imported by llsc_ctrl and llsc_link_reg.
package llsc_ctrl_pkg;

    // Active level of the synchronous reset input.
    localparam logic ResetEnable  = 1'b1;
    // Active / inactive levels of a register write enable.
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // Width of the MEM-stage operation class field.
    localparam int unsigned MEM_OP_W = 3;

    // MEM-stage operation classes.  Codes 5..7 are unused and behave as NOP.
    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NOP   = 3'd0,
        MEM_LOAD  = 3'd1,
        MEM_STORE = 3'd2,
        MEM_LL    = 3'd3,
        MEM_SC    = 3'd4
    } mem_op_e;

    // LLbit write presented to the LLbit register in WB.
    typedef struct packed {
        logic we;     // write enable
        logic value;  // value written when we is set
    } llbit_wb_t;

    localparam llbit_wb_t LLBIT_WB_IDLE = '{we: WriteDisable, value: 1'b0};
    localparam llbit_wb_t LLBIT_WB_SET  = '{we: WriteEnable,  value: 1'b1};
    localparam llbit_wb_t LLBIT_WB_CLR  = '{we: WriteEnable,  value: 1'b0};

    // Effective LLbit: an LLbit write still sitting in WB wins over the
    // architectural register, which has not yet been updated by it.
    function automatic logic llbit_forward(input llbit_wb_t wb, input logic current);
        return (wb.we == WriteEnable) ? wb.value : current;
    endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// Reservation register for LL/SC: holds the link-valid flag and the word address.
// Ports: clock/reset; set_i loads addr_i and marks the link valid; clr_i drops
// the link (address kept); link_valid_o/link_addr_o are the registered state.
// Latency: one cycle from control to output.  No backpressure; the caller
// gates set/clear with stall/flush.
module llsc_link_reg
    import llsc_ctrl_pkg::*;
#(
    parameter int unsigned AW = 30   // word-address width
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          set_i,
    input  logic          clr_i,
    input  logic [AW-1:0] addr_i,
    output logic          link_valid_o,
    output logic [AW-1:0] link_addr_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q,  addr_d;

    // Set wins over clear; the controller never asserts both, but a
    // defined priority keeps the register well behaved regardless.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset == ResetEnable) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign link_valid_o = valid_q;
    assign link_addr_o  = addr_q;

endmodule

// File: rtl/llsc_ctrl.sv
// LL/SC controller: tracks the load-linked reservation, decides SC success
// combinationally in MEM and issues the LLbit update one cycle later in WB.
// Ports: clock/reset; stall/flush pipeline controls; mem_op/mem_addr MEM op;
// LLbit_current architectural LLbit; sc_result/sc_mem_we SC outcome (same
// cycle); LLbit_we_wb/LLbit_value_wb registered LLbit write; link_valid/
// link_addr reservation state.  Latency: SC result 0 cycles, LLbit write 1.
// Backpressure: stall freezes the reservation and injects a WB bubble.
module llsc_ctrl
    import llsc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic                LLbit_current,
    output logic [DATA_W-1:0]   sc_result,
    output logic                sc_mem_we,
    output logic                LLbit_we_wb,
    output logic                LLbit_value_wb,
    output logic                link_valid,
    output logic [ADDR_W-3:0]   link_addr
);

    localparam int unsigned AW = ADDR_W - 2;

    mem_op_e   op;
    logic [AW-1:0] word_addr;
    logic      llbit_eff;
    logic      addr_hit;
    logic      sc_ok;
    logic      link_set;
    logic      link_clr;
    llbit_wb_t wb_q, wb_d;

    assign op        = mem_op_e'(mem_op);
    // Byte offset is irrelevant: reservations are per word.
    assign word_addr = mem_addr[ADDR_W-1:2];

    assign llbit_eff = llbit_forward(wb_q, LLbit_current);
    assign addr_hit  = link_valid && (word_addr == link_addr);
    assign sc_ok     = (op == MEM_SC) && llbit_eff && addr_hit;

    // sc_result is the value the SC would write to rt; a flushed SC never
    // retires, so report failure for it.  The memory write additionally
    // needs the MEM stage to actually advance.
    assign sc_result = (sc_ok && !flush) ? DATA_W'(1) : '0;
    assign sc_mem_we = sc_ok && !flush && !stall;

    // Reservation and WB-stage control.  Flush dominates stall, which
    // dominates the operation itself.
    always_comb begin
        link_set = 1'b0;
        link_clr = 1'b0;
        wb_d     = LLBIT_WB_IDLE;
        if (flush) begin
            link_clr = 1'b1;
        end else if (!stall) begin
            case (op)
                MEM_LL: begin
                    link_set = 1'b1;
                    wb_d     = LLBIT_WB_SET;
                end
                MEM_SC: begin
                    // Success or failure, an SC always consumes the link.
                    link_clr = 1'b1;
                    wb_d     = LLBIT_WB_CLR;
                end
                MEM_STORE: begin
                    // A plain store into the reserved word breaks the link.
                    if (addr_hit) begin
                        link_clr = 1'b1;
                        wb_d     = LLBIT_WB_CLR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset == ResetEnable) begin
            wb_q <= LLBIT_WB_IDLE;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign LLbit_we_wb    = wb_q.we;
    assign LLbit_value_wb = wb_q.value;

    llsc_link_reg #(
        .AW (AW)
    ) u_link_reg (
        .clock        (clock),
        .reset        (reset),
        .set_i        (link_set),
        .clr_i        (link_clr),
        .addr_i       (word_addr),
        .link_valid_o (link_valid),
        .link_addr_o  (link_addr)
    );

endmodule

// File: tb/tb_llsc_ctrl.sv
module tb_llsc_ctrl;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic        LLbit_current;
    logic [31:0] sc_result;
    logic        sc_mem_we;
    logic        LLbit_we_wb;
    logic        LLbit_value_wb;
    logic        link_valid;
    logic [29:0] link_addr;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ST = 3'd2, LL = 3'd3, SC = 3'd4;

    llsc_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .mem_op         (mem_op),
        .mem_addr       (mem_addr),
        .LLbit_current  (LLbit_current),
        .sc_result      (sc_result),
        .sc_mem_we      (sc_mem_we),
        .LLbit_we_wb    (LLbit_we_wb),
        .LLbit_value_wb (LLbit_value_wb),
        .link_valid     (link_valid),
        .link_addr      (link_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        fl;
        logic [2:0]  op;
        logic [31:0] addr;
        logic        llc;
        logic [31:0] e_res;  // during the cycle
        logic        e_mwe;  // during the cycle
        logic        e_we;   // after the edge
        logic        e_val;
        logic        e_lv;
        logic [29:0] e_la;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stl, logic fl, logic [2:0] op,
                                logic [31:0] addr, logic llc, logic [31:0] e_res,
                                logic e_mwe, logic e_we, logic e_val, logic e_lv,
                                logic [29:0] e_la);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.op = op; v.addr = addr; v.llc = llc;
        v.e_res = e_res; v.e_mwe = e_mwe; v.e_we = e_we; v.e_val = e_val;
        v.e_lv = e_lv; v.e_la = e_la;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic fl,
                         input logic [2:0] op, input logic [31:0] addr, input logic llc);
        reset = rst; stall = stl; flush = fl; mem_op = op; mem_addr = addr;
        LLbit_current = llc;
    endtask

    int clr_cnt;
    int mwe_cnt;

    initial begin
        //        rst stl fl op   addr      llc  res mwe  we val lv  la
        vecs.push_back(mk(1, 0, 0, NOP, 32'h000, 0,  0, 0,  0, 0, 0, 30'h000)); // 0 reset
        // LL then SC next cycle, LLbit only via forward
        vecs.push_back(mk(0, 0, 0, LL,  32'h100, 0,  0, 0,  1, 1, 1, 30'h040)); // 1
        vecs.push_back(mk(0, 0, 0, SC,  32'h100, 0,  1, 1,  1, 0, 0, 30'h040)); // 2
        vecs.push_back(mk(0, 0, 0, NOP, 32'h000, 0,  0, 0,  0, 0, 0, 30'h040)); // 3
        // LL, store into same word (byte 2), SC fails
        vecs.push_back(mk(0, 0, 0, LL,  32'h100, 0,  0, 0,  1, 1, 1, 30'h040)); // 4
        vecs.push_back(mk(0, 0, 0, ST,  32'h102, 0,  0, 0,  1, 0, 0, 30'h040)); // 5
        vecs.push_back(mk(0, 0, 0, SC,  32'h100, 1,  0, 0,  1, 0, 0, 30'h040)); // 6
        // LL, store to other word, SC succeeds with LLbit from register
        vecs.push_back(mk(0, 0, 0, LL,  32'h100, 0,  0, 0,  1, 1, 1, 30'h040)); // 7
        vecs.push_back(mk(0, 0, 0, ST,  32'h104, 0,  0, 0,  0, 0, 1, 30'h040)); // 8
        vecs.push_back(mk(0, 0, 0, SC,  32'h100, 1,  1, 1,  1, 0, 0, 30'h040)); // 9
        // reservation valid but LLbit register 0 and no forward: fail
        vecs.push_back(mk(0, 0, 0, LL,  32'h200, 0,  0, 0,  1, 1, 1, 30'h080)); // 10
        vecs.push_back(mk(0, 0, 0, LD,  32'h200, 0,  0, 0,  0, 0, 1, 30'h080)); // 11
        vecs.push_back(mk(0, 0, 0, SC,  32'h200, 0,  0, 0,  1, 0, 0, 30'h080)); // 12
        // byte offset ignored
        vecs.push_back(mk(0, 0, 0, LL,  32'h203, 0,  0, 0,  1, 1, 1, 30'h080)); // 13
        vecs.push_back(mk(0, 0, 0, SC,  32'h201, 0,  1, 1,  1, 0, 0, 30'h080)); // 14
        // LL overwrites reservation; SC to old address fails
        vecs.push_back(mk(0, 0, 0, LL,  32'h300, 0,  0, 0,  1, 1, 1, 30'h0C0)); // 15
        vecs.push_back(mk(0, 0, 0, LL,  32'h400, 0,  0, 0,  1, 1, 1, 30'h100)); // 16
        vecs.push_back(mk(0, 0, 0, SC,  32'h300, 0,  0, 0,  1, 0, 0, 30'h100)); // 17
        // LL, flush, idle, SC
        vecs.push_back(mk(0, 0, 0, LL,  32'h100, 0,  0, 0,  1, 1, 1, 30'h040)); // 18
        vecs.push_back(mk(0, 0, 1, NOP, 32'h000, 0,  0, 0,  0, 0, 0, 30'h040)); // 19
        vecs.push_back(mk(0, 0, 0, NOP, 32'h000, 1,  0, 0,  0, 0, 0, 30'h040)); // 20
        vecs.push_back(mk(0, 0, 0, SC,  32'h100, 1,  0, 0,  1, 0, 0, 30'h040)); // 21
        // flush beats stall and LL
        vecs.push_back(mk(0, 1, 1, LL,  32'h500, 0,  0, 0,  0, 0, 0, 30'h040)); // 22
        // SC stalled two cycles then released
        vecs.push_back(mk(0, 0, 0, LL,  32'h100, 0,  0, 0,  1, 1, 1, 30'h040)); // 23
        vecs.push_back(mk(0, 1, 0, SC,  32'h100, 0,  1, 0,  0, 0, 1, 30'h040)); // 24
        vecs.push_back(mk(0, 1, 0, SC,  32'h100, 1,  1, 0,  0, 0, 1, 30'h040)); // 25
        vecs.push_back(mk(0, 0, 0, SC,  32'h100, 1,  1, 1,  1, 0, 0, 30'h040)); // 26
        vecs.push_back(mk(0, 0, 0, NOP, 32'h000, 0,  0, 0,  0, 0, 0, 30'h040)); // 27
        // LL, reset (beats LL), SC fails
        vecs.push_back(mk(0, 0, 0, LL,  32'h100, 0,  0, 0,  1, 1, 1, 30'h040)); // 28
        vecs.push_back(mk(1, 0, 0, LL,  32'h600, 0,  0, 0,  0, 0, 0, 30'h000)); // 29
        vecs.push_back(mk(0, 0, 0, SC,  32'h100, 0,  0, 0,  1, 0, 0, 30'h000)); // 30
        // reset beats flush and stall
        vecs.push_back(mk(0, 0, 0, LL,  32'h700, 0,  0, 0,  1, 1, 1, 30'h1C0)); // 31
        vecs.push_back(mk(1, 1, 1, ST,  32'h700, 0,  0, 0,  0, 0, 0, 30'h000)); // 32
        // store matching word while no link: no LLbit write
        vecs.push_back(mk(0, 0, 0, ST,  32'h000, 0,  0, 0,  0, 0, 0, 30'h000)); // 33

        drive(1, 0, 0, NOP, 32'h0, 0);
        @(posedge clock); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].fl, vecs[i].op, vecs[i].addr, vecs[i].llc);
            #3;
            chk("sc_result", i, sc_result, vecs[i].e_res);
            chk("sc_mem_we", i, 32'(sc_mem_we), 32'(vecs[i].e_mwe));
            @(posedge clock); #1;
            chk("LLbit_we_wb", i, 32'(LLbit_we_wb), 32'(vecs[i].e_we));
            chk("LLbit_value_wb", i, 32'(LLbit_value_wb), 32'(vecs[i].e_val));
            chk("link_valid", i, 32'(link_valid), 32'(vecs[i].e_lv));
            chk("link_addr", i, 32'(link_addr), 32'(vecs[i].e_la));
        end

        // Stalled SC: count memory writes and LLbit clears over a bounded window.
        drive(0, 0, 0, LL, 32'h800, 0);
        @(posedge clock); #1;
        clr_cnt = 0;
        mwe_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (c < 2)       drive(0, 1, 0, SC, 32'h800, 1);
            else if (c == 2) drive(0, 0, 0, SC, 32'h800, 1);
            else             drive(0, 0, 0, NOP, 32'h0, 0);
            #3;
            if (sc_mem_we) mwe_cnt++;
            @(posedge clock); #1;
            if (LLbit_we_wb && !LLbit_value_wb) clr_cnt++;
        end
        chk("stall_seq_mem_we_count", 0, 32'(mwe_cnt), 32'd1);
        chk("stall_seq_clear_count", 0, 32'(clr_cnt), 32'd1);
        chk("stall_seq_link_valid", 0, 32'(link_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
